// File: rtl/mc_control_unit_if.sv
// ---------------------------------------------------------------------------
// mc_control_unit_if
//
// Bundles the control unit's datapath-facing signals: the instruction fields
// and ALU flags coming in, and the register strobes, mux selects, state code
// and exception status going out.
//
// Modports:
//   master -- the control unit: samples Op/Funct/ALU flags, drives all
//             strobes, selects, StateOut, Cause and Halted.
//   slave  -- the datapath side: drives Op/Funct/ALU flags, consumes the rest.
//
// Signal summary:
//   Op[5:0], Funct[5:0]     instruction opcode [31:26] and function [5:0]
//   ALU_zero, ALU_overflow  ALU result flags
//   StateOut[7:0]           current state code, zero-extended
//   PC_load .. wr           register write strobes (wr = memory write)
//   IorD, ALUSrcA, RegDst   1-bit mux selects
//   MemtoReg, ALUSrcB,
//   PCSource                2-bit mux selects
//   ALU_sel[2:0]            ALU operation
//   Cause[1:0]              last exception cause (registered)
//   Halted                  processor stopped on break
// ---------------------------------------------------------------------------
interface mc_control_unit_if;

    logic [5:0] Op;
    logic [5:0] Funct;
    logic       ALU_zero;
    logic       ALU_overflow;

    logic [7:0] StateOut;
    logic       PC_load;
    logic       IR_load;
    logic       MDR_load;
    logic       A_load;
    logic       B_load;
    logic       ALUOut_load;
    logic       EPC_load;
    logic       RegWrite;
    logic       wr;
    logic       IorD;
    logic       ALUSrcA;
    logic       RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [2:0] ALU_sel;
    logic [1:0] Cause;
    logic       Halted;

    modport master (
        input  Op, Funct, ALU_zero, ALU_overflow,
        output StateOut, PC_load, IR_load, MDR_load, A_load, B_load,
               ALUOut_load, EPC_load, RegWrite, wr, IorD, ALUSrcA, RegDst,
               MemtoReg, ALUSrcB, PCSource, ALU_sel, Cause, Halted
    );

    modport slave (
        output Op, Funct, ALU_zero, ALU_overflow,
        input  StateOut, PC_load, IR_load, MDR_load, A_load, B_load,
               ALUOut_load, EPC_load, RegWrite, wr, IorD, ALUSrcA, RegDst,
               MemtoReg, ALUSrcB, PCSource, ALU_sel, Cause, Halted
    );

endinterface

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
//
// Multi-cycle MIPS-style control FSM. Sequences fetch, decode, execute,
// memory and write-back for add/sub/and/xor, beq/bne, lw/sw, lui and j,
// raises exceptions on illegal opcodes and arithmetic overflow, and stops
// in HALT on break until Reset.
//
// Parameters:
//   MEM_WAIT   memory wait cycles after FETCH and LW_READ (0..15, 0 = none)
//   EXC_VECTOR PCSource code that selects the exception vector
//
// Ports:
//   Clk    sole clock, rising edge
//   Reset  synchronous, active-high; returns to FETCH from any state
//   bus    mc_control_unit_if.master -- instruction fields, ALU flags in;
//          strobes, selects, StateOut, Cause, Halted out
// ---------------------------------------------------------------------------
module mc_control_unit #(
    parameter int unsigned MEM_WAIT   = 2,
    parameter logic [1:0]  EXC_VECTOR = 2'b11
) (
    input  logic               Clk,
    input  logic               Reset,
    mc_control_unit_if.master  bus
);

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_FWAIT    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_R_EXEC   = 4'd3,
        ST_R_WB     = 4'd4,
        ST_BRANCH   = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_LW_READ  = 4'd7,
        ST_LW_WAIT  = 4'd8,
        ST_LW_WB    = 4'd9,
        ST_SW_WRITE = 4'd10,
        ST_LUI_WB   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_EXCEPT   = 4'd13,
        ST_HALT     = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JUMP  = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_BREAK = 6'h0d;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_XOR   = 6'h26;

    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_LUI   = 3'b101;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_OVF     = 2'b10;

    // Counter preload on wait-state entry; the wait state exits when the
    // counter reads zero, so it lasts exactly MEM_WAIT cycles.
    localparam logic [3:0] WAIT_LOAD = (MEM_WAIT == 0) ? 4'd0 : 4'(MEM_WAIT - 1);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt, wait_nxt;
    logic [1:0] cause, cause_nxt;
    // Op/Funct captured in DECODE; later states use these rather than the
    // live inputs so the sequence only depends on the decoded instruction.
    logic [5:0] op_q, op_nxt;
    logic [5:0] funct_q, funct_nxt;

    function automatic logic alu_funct(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_XOR);
    endfunction

    function automatic logic [2:0] alu_for_funct(input logic [5:0] f);
        logic [2:0] sel;
        sel = ALU_PASSA;
        unique case (f)
            FN_ADD:  sel = ALU_ADD;
            FN_SUB:  sel = ALU_SUB;
            FN_AND:  sel = ALU_AND;
            FN_XOR:  sel = ALU_XOR;
            default: sel = ALU_PASSA;
        endcase
        return sel;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_FETCH;
            wait_cnt <= 4'd0;
            cause    <= CAUSE_NONE;
            op_q     <= 6'd0;
            funct_q  <= 6'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            cause    <= cause_nxt;
            op_q     <= op_nxt;
            funct_q  <= funct_nxt;
        end
    end

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        cause_nxt = cause;
        op_nxt    = op_q;
        funct_nxt = funct_q;

        bus.PC_load     = 1'b0;
        bus.IR_load     = 1'b0;
        bus.MDR_load    = 1'b0;
        bus.A_load      = 1'b0;
        bus.B_load      = 1'b0;
        bus.ALUOut_load = 1'b0;
        bus.EPC_load    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.wr          = 1'b0;
        bus.IorD        = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.RegDst      = 1'b0;
        bus.MemtoReg    = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.PCSource    = 2'b00;
        bus.ALU_sel     = ALU_PASSA;
        bus.Halted      = 1'b0;

        unique case (state)
            ST_FETCH: begin
                // Instruction read and PC+4 in the same cycle.
                bus.IR_load  = 1'b1;
                bus.MDR_load = 1'b1;
                bus.ALUSrcB  = 2'b01;
                bus.ALU_sel  = ALU_ADD;
                bus.PC_load  = 1'b1;
                if (MEM_WAIT == 0) begin
                    state_nxt = ST_DECODE;
                end else begin
                    state_nxt = ST_FWAIT;
                    wait_nxt  = WAIT_LOAD;
                end
            end

            ST_FWAIT: begin
                bus.IR_load  = 1'b1;
                bus.MDR_load = 1'b1;
                if (wait_cnt == 4'd0) begin
                    state_nxt = ST_DECODE;
                end else begin
                    wait_nxt = wait_cnt - 4'd1;
                end
            end

            ST_DECODE: begin
                // Register read plus speculative branch target.
                bus.A_load      = 1'b1;
                bus.B_load      = 1'b1;
                bus.ALUOut_load = 1'b1;
                bus.ALUSrcB     = 2'b11;
                bus.ALU_sel     = ALU_ADD;
                op_nxt          = bus.Op;
                funct_nxt       = bus.Funct;
                if (bus.Op == OP_RTYPE) begin
                    if (alu_funct(bus.Funct)) begin
                        state_nxt = ST_R_EXEC;
                    end else if (bus.Funct == FN_NOP) begin
                        state_nxt = ST_FETCH;
                    end else if (bus.Funct == FN_BREAK) begin
                        state_nxt = ST_HALT;
                    end else begin
                        state_nxt = ST_EXCEPT;
                        cause_nxt = CAUSE_ILLEGAL;
                    end
                end else begin
                    unique case (bus.Op)
                        OP_BEQ, OP_BNE: state_nxt = ST_BRANCH;
                        OP_LW,  OP_SW:  state_nxt = ST_MEM_ADDR;
                        OP_LUI:         state_nxt = ST_LUI_WB;
                        OP_JUMP:        state_nxt = ST_JUMP;
                        default: begin
                            state_nxt = ST_EXCEPT;
                            cause_nxt = CAUSE_ILLEGAL;
                        end
                    endcase
                end
            end

            ST_R_EXEC: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALU_sel     = alu_for_funct(funct_q);
                bus.ALUOut_load = 1'b1;
                // Only add/sub trap on overflow; and/xor ignore the flag.
                if (bus.ALU_overflow && ((funct_q == FN_ADD) || (funct_q == FN_SUB))) begin
                    state_nxt = ST_EXCEPT;
                    cause_nxt = CAUSE_OVF;
                end else begin
                    state_nxt = ST_R_WB;
                end
            end

            ST_R_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                state_nxt    = ST_FETCH;
            end

            ST_BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALU_sel  = ALU_SUB;
                bus.PCSource = 2'b01;
                bus.PC_load  = (op_q == OP_BEQ) ? bus.ALU_zero : ~bus.ALU_zero;
                state_nxt    = ST_FETCH;
            end

            ST_MEM_ADDR: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUSrcB     = 2'b10;
                bus.ALU_sel     = ALU_ADD;
                bus.ALUOut_load = 1'b1;
                state_nxt       = (op_q == OP_LW) ? ST_LW_READ : ST_SW_WRITE;
            end

            ST_LW_READ: begin
                bus.IorD     = 1'b1;
                bus.MDR_load = 1'b1;
                if (MEM_WAIT == 0) begin
                    state_nxt = ST_LW_WB;
                end else begin
                    state_nxt = ST_LW_WAIT;
                    wait_nxt  = WAIT_LOAD;
                end
            end

            ST_LW_WAIT: begin
                bus.IorD     = 1'b1;
                bus.MDR_load = 1'b1;
                if (wait_cnt == 4'd0) begin
                    state_nxt = ST_LW_WB;
                end else begin
                    wait_nxt = wait_cnt - 4'd1;
                end
            end

            ST_LW_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 2'b01;
                state_nxt    = ST_FETCH;
            end

            ST_SW_WRITE: begin
                bus.IorD  = 1'b1;
                bus.wr    = 1'b1;
                state_nxt = ST_FETCH;
            end

            ST_LUI_WB: begin
                bus.ALU_sel  = ALU_LUI;
                bus.ALUSrcB  = 2'b10;
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 2'b10;
                state_nxt    = ST_FETCH;
            end

            ST_JUMP: begin
                bus.PCSource = 2'b10;
                bus.PC_load  = 1'b1;
                state_nxt    = ST_FETCH;
            end

            ST_EXCEPT: begin
                // Save the faulting PC and redirect to the handler; Cause
                // was already written on the way in and is left untouched.
                bus.EPC_load = 1'b1;
                bus.PCSource = EXC_VECTOR;
                bus.PC_load  = 1'b1;
                state_nxt    = ST_FETCH;
            end

            ST_HALT: begin
                bus.Halted = 1'b1;
            end

            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

    assign bus.StateOut = {4'b0000, state};
    assign bus.Cause    = cause;

endmodule

// File: tb/tb_mc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_control_unit
//
// Two control units, MEM_WAIT=2 (unit A) and MEM_WAIT=0 (unit B), share the
// instruction/flag inputs; the idle one is held in Reset. Every cycle the
// full output vector of the active unit is compared against a reference
// built from the instruction's expected state trace and a per-state output
// table.
// ---------------------------------------------------------------------------
module tb_mc_control_unit;

    logic       Clk = 1'b0;
    logic       rst_a, rst_b;
    logic [5:0] op_i, funct_i;
    logic       zero_i, ovf_i;
    logic       sel;          // 0: unit A active, 1: unit B active

    int         n_chk = 0;
    int         n_bad = 0;
    int         n_instr = 0;
    logic [1:0] cause_m;      // modelled Cause register of the active unit
    int         trace[$];
    logic [1:0] tr_cause;

    always #5 Clk = ~Clk;

    mc_control_unit_if if_a ();
    mc_control_unit_if if_b ();

    assign if_a.Op = op_i;   assign if_a.Funct = funct_i;
    assign if_a.ALU_zero = zero_i;  assign if_a.ALU_overflow = ovf_i;
    assign if_b.Op = op_i;   assign if_b.Funct = funct_i;
    assign if_b.ALU_zero = zero_i;  assign if_b.ALU_overflow = ovf_i;

    mc_control_unit #(.MEM_WAIT(2), .EXC_VECTOR(2'b11)) dut_a (
        .Clk(Clk), .Reset(rst_a), .bus(if_a));
    mc_control_unit #(.MEM_WAIT(0), .EXC_VECTOR(2'b11)) dut_b (
        .Clk(Clk), .Reset(rst_b), .bus(if_b));

    logic [31:0] obs_a, obs_b, obs;
    assign obs_a = {if_a.StateOut, if_a.PC_load, if_a.IR_load, if_a.MDR_load,
                    if_a.A_load, if_a.B_load, if_a.ALUOut_load, if_a.EPC_load,
                    if_a.RegWrite, if_a.wr, if_a.IorD, if_a.ALUSrcA, if_a.RegDst,
                    if_a.MemtoReg, if_a.ALUSrcB, if_a.PCSource, if_a.ALU_sel,
                    if_a.Cause, if_a.Halted};
    assign obs_b = {if_b.StateOut, if_b.PC_load, if_b.IR_load, if_b.MDR_load,
                    if_b.A_load, if_b.B_load, if_b.ALUOut_load, if_b.EPC_load,
                    if_b.RegWrite, if_b.wr, if_b.IorD, if_b.ALUSrcA, if_b.RegDst,
                    if_b.MemtoReg, if_b.ALUSrcB, if_b.PCSource, if_b.ALU_sel,
                    if_b.Cause, if_b.Halted};
    assign obs = sel ? obs_b : obs_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output table: what each state must drive, packed like obs.
    function automatic logic [31:0] exp_word(input int st, input logic [5:0] op,
                                             input logic [5:0] funct, input logic z,
                                             input logic [1:0] cause);
        logic pcl, irl, mdrl, al, bl, aol, epcl, rw, w, iord, srca, rdst, h;
        logic [1:0] m2r, srcb, pcs;
        logic [2:0] alu;
        {pcl, irl, mdrl, al, bl, aol, epcl, rw, w, iord, srca, rdst, h} = '0;
        m2r = 2'b00; srcb = 2'b00; pcs = 2'b00; alu = 3'b000;
        case (st)
            0: begin irl = 1; mdrl = 1; srcb = 2'b01; alu = 3'b001; pcl = 1; end
            1: begin irl = 1; mdrl = 1; end
            2: begin al = 1; bl = 1; aol = 1; srcb = 2'b11; alu = 3'b001; end
            3: begin
                srca = 1; aol = 1;
                case (funct)
                    6'h20: alu = 3'b001;
                    6'h22: alu = 3'b010;
                    6'h24: alu = 3'b011;
                    6'h26: alu = 3'b100;
                    default: alu = 3'b000;
                endcase
            end
            4: begin rw = 1; rdst = 1; end
            5: begin srca = 1; alu = 3'b010; pcs = 2'b01; pcl = (op == 6'h04) ? z : !z; end
            6: begin srca = 1; srcb = 2'b10; alu = 3'b001; aol = 1; end
            7, 8: begin iord = 1; mdrl = 1; end
            9: begin rw = 1; m2r = 2'b01; end
            10: begin iord = 1; w = 1; end
            11: begin alu = 3'b101; srcb = 2'b10; rw = 1; m2r = 2'b10; end
            12: begin pcs = 2'b10; pcl = 1; end
            13: begin epcl = 1; pcs = 2'b11; pcl = 1; end
            14: h = 1;
            default: ;
        endcase
        return {8'(st), pcl, irl, mdrl, al, bl, aol, epcl, rw, w, iord, srca, rdst,
                m2r, srcb, pcs, alu, cause, h};
    endfunction

    // Expected state sequence of one instruction, FETCH through its last state.
    function automatic void build_trace(input logic [5:0] op, input logic [5:0] funct,
                                        input logic ov, input int mw);
        trace.delete();
        tr_cause = 2'b00;
        trace.push_back(0);
        for (int i = 0; i < mw; i++) trace.push_back(1);
        trace.push_back(2);
        if (op == 6'h00) begin
            if (funct inside {6'h20, 6'h22, 6'h24, 6'h26}) begin
                trace.push_back(3);
                if (ov && (funct == 6'h20 || funct == 6'h22)) begin
                    trace.push_back(13); tr_cause = 2'b10;
                end else begin
                    trace.push_back(4);
                end
            end else if (funct == 6'h0d) begin
                trace.push_back(14);
            end else if (funct != 6'h00) begin
                trace.push_back(13); tr_cause = 2'b01;
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            trace.push_back(5);
        end else if (op == 6'h23) begin
            trace.push_back(6); trace.push_back(7);
            for (int i = 0; i < mw; i++) trace.push_back(8);
            trace.push_back(9);
        end else if (op == 6'h2b) begin
            trace.push_back(6); trace.push_back(10);
        end else if (op == 6'h0f) begin
            trace.push_back(11);
        end else if (op == 6'h02) begin
            trace.push_back(12);
        end else begin
            trace.push_back(13); tr_cause = 2'b01;
        end
    endfunction

    task automatic set_reset(input logic v);
        if (sel) rst_b = v; else rst_a = v;
    endtask

    // Called just after a rising edge with the active unit in FETCH; returns
    // just after the edge that brings it back to FETCH (or into HALT's
    // second cycle for break). reset_at >= 0 asserts Reset in that cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                             input logic z, input logic ov, input int reset_at);
        int  mw;
        bit  done;
        mw = sel ? 0 : 2;
        done = 0;
        build_trace(op, funct, ov, mw);
        op_i = op; funct_i = funct; zero_i = z; ovf_i = ov;
        foreach (trace[k]) begin
            if (!done) begin
                if (k == reset_at) set_reset(1'b1);
                if (trace[k] == 13) cause_m = tr_cause;
                @(negedge Clk);
                check($sformatf("u%0d i%0d op%h fn%h st%0d", sel, n_instr, op, funct, trace[k]),
                      obs, exp_word(trace[k], op, funct, z, cause_m));
                @(posedge Clk); #1;
                if (k == reset_at) begin
                    set_reset(1'b0);
                    cause_m = 2'b00;
                    done = 1;
                end
            end
        end
        n_instr++;
    endtask

    task automatic run_random(input int count);
        logic [5:0] op, fn;
        for (int n = 0; n < count; n++) begin
            op = 6'h00;
            fn = 6'h20;
            case ($urandom_range(0, 9))
                0, 9: fn = 6'h20 + 6'($urandom_range(0, 3) * 2);
                1:    fn = 6'h00;
                2: begin
                    fn = 6'($urandom_range(0, 63));
                    if (fn inside {6'h00, 6'h0d, 6'h20, 6'h22, 6'h24, 6'h26}) fn = 6'h3f;
                end
                3: op = ($urandom_range(0, 1) == 1) ? 6'h05 : 6'h04;
                4: op = 6'h23;
                5: op = 6'h2b;
                6: op = 6'h0f;
                7: op = 6'h02;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    fn = 6'($urandom_range(0, 63));
                    if (op == 6'h00 && fn == 6'h0d) fn = 6'h24;
                end
            endcase
            run_instr(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1; cause_m = 2'b00;
        op_i = 6'h00; funct_i = 6'h00; zero_i = 1'b0; ovf_i = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_a", obs_a, exp_word(0, 6'h00, 6'h00, 1'b0, 2'b00));
        check("reset_b", obs_b, exp_word(0, 6'h00, 6'h00, 1'b0, 2'b00));
        @(posedge Clk); #1;
        rst_a = 1'b0;

        // Unit A, MEM_WAIT=2.
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, -1);   // add: 0,1,1,2,3,4
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, -1);   // beq not taken
        run_instr(6'h05, 6'h00, 1'b0, 1'b0, -1);   // bne taken
        run_instr(6'h00, 6'h22, 1'b0, 1'b1, -1);   // sub overflow -> EXCEPT
        run_instr(6'h00, 6'h24, 1'b0, 1'b1, -1);   // and ignores overflow
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, 2);    // Reset in 2nd FWAIT
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, -1);   // fresh full wait
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, -1);   // lw with LW_WAIT
        run_random(150);
        run_instr(6'h3f, 6'h00, 1'b0, 1'b0, -1);   // illegal op
        run_instr(6'h00, 6'h0d, 1'b0, 1'b0, -1);   // break -> HALT
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            check($sformatf("halt_hold c%0d", i), obs, exp_word(14, 6'h00, 6'h0d, 1'b0, cause_m));
            @(posedge Clk); #1;
        end
        set_reset(1'b1);
        @(negedge Clk);
        check("halt_in_reset", obs, exp_word(14, 6'h00, 6'h0d, 1'b0, cause_m));
        @(posedge Clk); #1;
        set_reset(1'b0);
        cause_m = 2'b00;
        run_instr(6'h00, 6'h00, 1'b0, 1'b0, -1);   // nop after halt reset

        // Unit B, MEM_WAIT=0.
        rst_a = 1'b1; rst_b = 1'b0; sel = 1'b1; cause_m = 2'b00;
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, -1);   // lw: 0,2,6,7,9
        run_instr(6'h2b, 6'h00, 1'b0, 1'b0, -1);   // sw: 0,2,6,10
        run_instr(6'h00, 6'h31, 1'b0, 1'b0, -1);   // illegal funct
        run_random(100);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
